// File: rtl/mac_pause_rx.sv
// mac_pause_rx -- receive-side 802.3x PAUSE detector and hold-off timer.
//
// Watches the MAC receive byte stream for MAC-control PAUSE frames addressed to this station (or to
// the reserved 01-80-C2-00-00-01 multicast address). When one is accepted, its pause_time is loaded
// into a quanta countdown. o_pause_active gates the transmit path while quanta remain. Runs entirely
// on the rx byte clock.
//
// Parameters
//   STATION_ADDR   own unicast MAC address, byte 0 (first on the wire) in bits [47:40]
//   QUANTA_CYCLES  clock cycles per pause quantum
//
// Ports
//   i_clk              byte clock
//   i_rst              asynchronous, active-high reset
//   i_rx_data    [7:0] received frame byte, destination address first, no preamble/SFD
//   i_rx_valid         i_rx_data carries a byte this cycle (idle gaps allowed inside a frame)
//   i_rx_last          final byte of the frame (only meaningful with i_rx_valid)
//   i_rx_good          frame passed FCS/length checks (sampled with i_rx_valid & i_rx_last)
//   i_pause_enable     0: frames are still parsed and counted, but the timer is not loaded
//   o_pause_active     high while o_pause_quanta is non-zero
//   o_pause_quanta [15:0] remaining pause quanta
//   o_pause_frame_stb  one-cycle pulse per accepted PAUSE frame
//   o_pause_frame_cnt [15:0] accepted PAUSE frames, saturating

module mac_pause_rx #(
  parameter logic [47:0] STATION_ADDR  = 48'h00_0A_35_00_01_02,
  parameter int unsigned QUANTA_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_last,
  input  logic        i_rx_good,
  input  logic        i_pause_enable,
  output logic        o_pause_active,
  output logic [15:0] o_pause_quanta,
  output logic        o_pause_frame_stb,
  output logic [15:0] o_pause_frame_cnt
);

  localparam logic [47:0] CtrlMcastAddr = 48'h01_80_C2_00_00_01;
  localparam int unsigned PrescW = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(QUANTA_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StWaitEnd,
    StDrop
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [4:0]        r_idx;
  logic              r_uc_ok;
  logic              r_mc_ok;
  logic [15:0]       r_ptime;
  logic              r_stb;
  logic [15:0]       r_cnt;
  logic [15:0]       r_quanta;
  logic [PrescW-1:0] r_presc;

  logic [7:0]  w_sta_byte;
  logic [7:0]  w_mc_byte;
  logic        w_uc_hit;
  logic        w_mc_hit;
  logic        w_hdr_bad;
  logic        w_parsing;
  logic        w_end;
  logic        w_commit;
  logic [15:0] w_ptime_next;

  // ---------------------------------------------------------------------------------------------
  // Byte-level decode
  // ---------------------------------------------------------------------------------------------

  assign w_parsing = (r_state == StIdle) || (r_state == StHdr);
  assign w_end     = i_rx_valid && i_rx_last;

  // Destination-address byte expected at the current index for each accepted address.
  always_comb begin
    w_sta_byte = 8'h00;
    w_mc_byte  = 8'h00;
    case (r_idx)
      5'd0: begin w_sta_byte = STATION_ADDR[47:40]; w_mc_byte = CtrlMcastAddr[47:40]; end
      5'd1: begin w_sta_byte = STATION_ADDR[39:32]; w_mc_byte = CtrlMcastAddr[39:32]; end
      5'd2: begin w_sta_byte = STATION_ADDR[31:24]; w_mc_byte = CtrlMcastAddr[31:24]; end
      5'd3: begin w_sta_byte = STATION_ADDR[23:16]; w_mc_byte = CtrlMcastAddr[23:16]; end
      5'd4: begin w_sta_byte = STATION_ADDR[15:8];  w_mc_byte = CtrlMcastAddr[15:8];  end
      5'd5: begin w_sta_byte = STATION_ADDR[7:0];   w_mc_byte = CtrlMcastAddr[7:0];   end
      default: ;
    endcase
  end

  // Running match per candidate address; byte 0 starts a fresh comparison.
  assign w_uc_hit = ((r_idx == 5'd0) || r_uc_ok) && (i_rx_data == w_sta_byte);
  assign w_mc_hit = ((r_idx == 5'd0) || r_mc_ok) && (i_rx_data == w_mc_byte);

  // Header byte rejects the frame. The DA fails as soon as neither candidate can still match.
  always_comb begin
    w_hdr_bad = 1'b0;
    case (r_idx)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: w_hdr_bad = !(w_uc_hit || w_mc_hit);
      5'd12:   w_hdr_bad = (i_rx_data != 8'h88);
      5'd13:   w_hdr_bad = (i_rx_data != 8'h08);
      5'd14:   w_hdr_bad = (i_rx_data != 8'h00);
      5'd15:   w_hdr_bad = (i_rx_data != 8'h01);
      default: w_hdr_bad = 1'b0;
    endcase
  end

  // pause_time including the byte arriving now, so a frame ending on byte 17 commits the full value.
  always_comb begin
    w_ptime_next = r_ptime;
    if (w_parsing && i_rx_valid) begin
      if (r_idx == 5'd16) begin
        w_ptime_next = {i_rx_data, r_ptime[7:0]};
      end else if (r_idx == 5'd17) begin
        w_ptime_next = {r_ptime[15:8], i_rx_data};
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // StIdle behaves as the header parser at byte 0; it exists so a reset or finished frame
  // always restarts parsing from a fresh first byte.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StHdr: begin
        if (i_rx_valid) begin
          if (i_rx_last) begin
            w_state_next = StIdle;
          end else if (w_hdr_bad) begin
            w_state_next = StDrop;
          end else if (r_idx == 5'd17) begin
            w_state_next = StWaitEnd;
          end else begin
            w_state_next = StHdr;
          end
        end
      end
      StWaitEnd, StDrop: begin
        if (w_end) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Commit decision on the last-byte cycle; frames ending before byte 17 are silently ignored.
  always_comb begin
    w_commit = 1'b0;
    unique case (r_state)
      StIdle, StHdr: w_commit = w_end && !w_hdr_bad && (r_idx == 5'd17) && i_rx_good;
      StWaitEnd:     w_commit = w_end && i_rx_good;
      StDrop:        w_commit = 1'b0;
      default:       w_commit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Parse state: byte index, DA match flags, pause_time capture
  // ---------------------------------------------------------------------------------------------

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= 5'd0;
      r_uc_ok <= 1'b0;
      r_mc_ok <= 1'b0;
      r_ptime <= 16'h0000;
    end else begin
      if (i_rx_valid) begin
        if (i_rx_last) begin
          r_idx <= 5'd0;
        end else if (r_idx != 5'd31) begin
          r_idx <= r_idx + 5'd1;
        end
      end
      if (w_parsing && i_rx_valid && (r_idx < 5'd6)) begin
        r_uc_ok <= w_uc_hit;
        r_mc_ok <= w_mc_hit;
      end
      r_ptime <= w_ptime_next;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Commit: strobe, counter and pause timer
  // ---------------------------------------------------------------------------------------------

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stb <= 1'b0;
      r_cnt <= 16'h0000;
    end else begin
      r_stb <= w_commit;
      if (w_commit && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // A committed reload wins over a decrement due in the same cycle; pause_time 0 cancels at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quanta <= 16'h0000;
      r_presc  <= '0;
    end else if (w_commit && i_pause_enable) begin
      r_quanta <= w_ptime_next;
      r_presc  <= '0;
    end else if (r_quanta != 16'h0000) begin
      if (r_presc == PrescMax) begin
        r_presc  <= '0;
        r_quanta <= r_quanta - 16'd1;
      end else begin
        r_presc <= r_presc + PrescW'(1);
      end
    end
  end

  assign o_pause_active    = (r_quanta != 16'h0000);
  assign o_pause_quanta    = r_quanta;
  assign o_pause_frame_stb = r_stb;
  assign o_pause_frame_cnt = r_cnt;

endmodule
